// File: rtl/b_rd_port_pkg.sv
// Shared definitions for the pointer-based buffer: output queue depth and
// the wrap-aware pointer distance used by both the read and write sides.
package b_rd_port_pkg;

    localparam int unsigned Q_DEPTH = 2;

    // Distance wr - rd modulo 2^pw; callers zero-extend pointers to 32 bits.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] wr,
        input logic [31:0] rd,
        input int unsigned pw
    );
        logic [31:0] mask_s;
        if (pw >= 32'd32) begin
            mask_s = 32'hFFFF_FFFF;
        end else begin
            mask_s = (32'd1 << pw) - 32'd1;
        end
        return (wr - rd) & mask_s;
    endfunction

endpackage

// File: rtl/b_out_queue.sv
// Two-entry registered FIFO between the synchronous RAM and the output stream.
// The head register drives the output directly so out_data is a flop output.
module b_out_queue
    import b_rd_port_pkg::*;
#(
    parameter int d_width = 32
) (
    input  logic               c_clk,
    input  logic               c_reset_n,
    input  logic               flush,
    input  logic               push,
    input  logic [d_width-1:0] push_data,
    input  logic               pop,
    output logic [1:0]         occ,
    output logic [d_width-1:0] head,
    output logic               valid
);

    logic [d_width-1:0] r_head;
    logic [d_width-1:0] r_tail;
    logic [1:0]         r_occ;

    // Entry storage and occupancy; flush only empties, stored data is don't-care.
    always_ff @(posedge c_clk or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_head <= {d_width{1'b0}};
            r_tail <= {d_width{1'b0}};
            r_occ  <= 2'd0;
        end else if (flush) begin
            r_occ  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= push_data;
                    end else begin
                        r_tail <= push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    assign occ   = r_occ;
    assign head  = r_head;
    assign valid = (r_occ != 2'd0);

endmodule

// File: rtl/b_rd_port.sv
// Read end of the pointer-based buffer: issues RAM reads against the writer's
// pointer, feeds a 2-entry output queue and returns rd_ptr to the writer.
module b_rd_port
    import b_rd_port_pkg::*;
#(
    parameter int c_width = 4,
    parameter int d_width = 32
) (
    input  logic               c_clk,
    input  logic               c_reset_n,
    input  logic [c_width:0]   wr_ptr,
    output logic [c_width:0]   rd_ptr,
    input  logic               flush,
    output logic               mem_ren,
    output logic [c_width-1:0] mem_raddr,
    input  logic [d_width-1:0] mem_rdata,
    output logic [d_width-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [c_width:0]   count
);

    logic [c_width:0] r_rd_ptr;
    logic             r_pend;
    logic [1:0]       w_occ;
    logic             w_pop;
    logic             w_mem_empty;
    logic [2:0]       w_need;
    logic             w_ren;

    assign w_pop       = out_valid & out_ready;
    assign w_mem_empty = (r_rd_ptr == wr_ptr);

    // Slots already committed after this cycle's pop; a read is only issued
    // when the queue is guaranteed room for its data one cycle later.
    assign w_need = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_ren  = c_reset_n & ~flush & ~w_mem_empty & (w_need < 3'(Q_DEPTH));

    // Read pointer and in-flight read flag.
    always_ff @(posedge c_clk or negedge c_reset_n) begin
        if (!c_reset_n) begin
            r_rd_ptr <= {(c_width+1){1'b0}};
            r_pend   <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= wr_ptr;
            r_pend   <= 1'b0;
        end else begin
            r_pend <= w_ren;
            if (w_ren) begin
                r_rd_ptr <= r_rd_ptr + {{c_width{1'b0}}, 1'b1};
            end
        end
    end

    b_out_queue #(
        .d_width (d_width)
    ) u_out_queue (
        .c_clk     (c_clk),
        .c_reset_n (c_reset_n),
        .flush     (flush),
        .push      (r_pend),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (out_data),
        .valid     (out_valid)
    );

    assign rd_ptr    = r_rd_ptr;
    assign mem_ren   = w_ren;
    assign mem_raddr = r_rd_ptr[c_width-1:0];
    assign count     = (c_width+1)'(ptr_diff(32'(wr_ptr), 32'(r_rd_ptr), c_width+1));

endmodule
